// File: rtl/mem_ctrl_pkg.sv
// Shared encodings for the byte-serial memory controller: widths, access sizes,
// FSM states and transaction owners.
package mem_ctrl_pkg;

   localparam int INSTRUCTION_ADDRESS_SIZE = 32;
   localparam int INSTRUCTION_SIZE         = 32;
   localparam int BYTES_PER_WORD           = INSTRUCTION_SIZE / 8;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_t;

   // Encoding 3 is reserved and behaves as a full word.
   function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
      case (size)
         SIZE_BYTE: size_to_bytes = 3'd1;
         SIZE_HALF: size_to_bytes = 3'd2;
         default:   size_to_bytes = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Single-port controller serialising instruction fetches and load/stores into
// little-endian byte transactions on the unified byte-wide RAM.
//
// state    | meaning
// ST_IDLE  | RAM bus quiet; sample requests, data side has priority
// ST_READ  | drive base+k, capture mem_din into lane k on the next edge
// ST_WRITE | drive base+k with write byte k and mem_wr high
// ST_DONE  | one-cycle completion pulse to the owner; requests ignored
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int ADDR_W = INSTRUCTION_ADDRESS_SIZE,
   parameter int DATA_W = INSTRUCTION_SIZE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              inst_req,
   input  logic [ADDR_W-1:0] inst_addr,
   output logic              inst_valid,
   output logic [ADDR_W-1:0] inst_valid_addr,
   output logic [DATA_W-1:0] inst_data,
   input  logic              data_req,
   input  logic              data_we,
   input  logic [1:0]        data_size,
   input  logic [ADDR_W-1:0] data_addr,
   input  logic [DATA_W-1:0] data_wdata,
   output logic              data_done,
   output logic [DATA_W-1:0] data_rdata,
   input  logic [7:0]        mem_din,
   output logic [7:0]        mem_dout,
   output logic [ADDR_W-1:0] mem_a,
   output logic              mem_wr
);

   state_t            state;
   owner_t            owner;
   logic [ADDR_W-1:0] base;
   logic [2:0]        cnt;
   logic [2:0]        nbytes;
   logic [DATA_W-1:0] wbuf;
   logic [DATA_W-1:0] rbuf;

   logic [2:0]        next_k;
   logic [ADDR_W-1:0] next_a;
   logic              last;
   logic [DATA_W-1:0] asm_word;

   assign next_k = cnt + 3'd1;
   assign next_a = base + ADDR_W'(next_k);
   assign last   = (next_k == nbytes);

   // Read buffer with the byte arriving this cycle merged into lane cnt.
   always_comb begin
      asm_word = rbuf;
      asm_word[{cnt[1:0], 3'b000} +: 8] = mem_din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state           <= ST_IDLE;
         owner           <= OWN_INST;
         base            <= '0;
         cnt             <= '0;
         nbytes          <= '0;
         wbuf            <= '0;
         rbuf            <= '0;
         inst_valid      <= 1'b0;
         inst_valid_addr <= '0;
         inst_data       <= '0;
         data_done       <= 1'b0;
         data_rdata      <= '0;
         mem_a           <= '0;
         mem_dout        <= '0;
         mem_wr          <= 1'b0;
      end else begin
         inst_valid <= 1'b0;
         data_done  <= 1'b0;
         case (state)
            ST_IDLE: begin
               mem_wr   <= 1'b0;
               mem_a    <= '0;
               mem_dout <= '0;
               cnt      <= '0;
               if (data_req) begin
                  owner  <= OWN_DATA;
                  base   <= data_addr;
                  nbytes <= size_to_bytes(data_size);
                  wbuf   <= data_wdata;
                  rbuf   <= '0;
                  mem_a  <= data_addr;
                  if (data_we) begin
                     state    <= ST_WRITE;
                     mem_wr   <= 1'b1;
                     mem_dout <= data_wdata[7:0];
                  end else begin
                     state <= ST_READ;
                  end
               end else if (inst_req) begin
                  owner  <= OWN_INST;
                  base   <= inst_addr;
                  nbytes <= 3'(BYTES_PER_WORD);
                  wbuf   <= '0;
                  rbuf   <= '0;
                  mem_a  <= inst_addr;
                  state  <= ST_READ;
               end
            end

            ST_READ: begin
               rbuf <= asm_word;
               if (last) begin
                  state <= ST_DONE;
                  cnt   <= '0;
                  mem_a <= '0;
                  if (owner == OWN_INST) begin
                     inst_valid      <= 1'b1;
                     inst_valid_addr <= base;
                     inst_data       <= asm_word;
                  end else begin
                     data_done  <= 1'b1;
                     data_rdata <= asm_word;
                  end
               end else begin
                  cnt   <= next_k;
                  mem_a <= next_a;
               end
            end

            ST_WRITE: begin
               if (last) begin
                  state      <= ST_DONE;
                  cnt        <= '0;
                  mem_wr     <= 1'b0;
                  mem_a      <= '0;
                  mem_dout   <= '0;
                  data_done  <= 1'b1;
                  data_rdata <= '0;
               end else begin
                  cnt      <= next_k;
                  mem_a    <= next_a;
                  mem_dout <= wbuf[{next_k[1:0], 3'b000} +: 8];
               end
            end

            ST_DONE: begin
               // Cooldown cycle lets the requester drop req before we sample again.
               mem_wr   <= 1'b0;
               mem_a    <= '0;
               mem_dout <= '0;
               state    <= ST_IDLE;
            end

            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed scenarios plus random fetch/load/store
// traffic compared against a byte-array reference memory.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_valid;
   logic [31:0] inst_valid_addr;
   logic [31:0] inst_data;
   logic        data_req;
   logic        data_we;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_done;
   logic [31:0] data_rdata;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;

   mem_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_valid(inst_valid),
      .inst_valid_addr(inst_valid_addr), .inst_data(inst_data),
      .data_req(data_req), .data_we(data_we), .data_size(data_size),
      .data_addr(data_addr), .data_wdata(data_wdata), .data_done(data_done),
      .data_rdata(data_rdata), .mem_din(mem_din), .mem_dout(mem_dout),
      .mem_a(mem_a), .mem_wr(mem_wr)
   );

   always #5 clk = ~clk;

   // RAM aliased on the low 12 address bits; the model memory uses the same aliasing.
   logic [7:0] ram [0:4095];
   logic [7:0] model_mem [0:4095];
   assign mem_din = ram[mem_a[11:0]];
   always @(posedge clk) if (mem_wr) ram[mem_a[11:0]] <= mem_dout;

   int total = 0;
   int bad = 0;

   logic [31:0] tr_a    [0:31];
   logic        tr_wr   [0:31];
   logic [7:0]  tr_dout [0:31];
   int          pulse_cyc;
   logic        pulse_inst, pulse_data;
   logic [31:0] got_data, got_vaddr;

   function automatic int nb(input logic [1:0] s);
      return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] addr, input int n);
      logic [31:0] r;
      logic [31:0] a;
      r = 32'h0;
      for (int k = 0; k < n; k++) begin
         a = addr + 32'(k);
         r[8*k +: 8] = model_mem[a[11:0]];
      end
      return r;
   endfunction

   task automatic model_write(input logic [31:0] addr, input int n, input logic [31:0] wd);
      logic [31:0] a;
      for (int k = 0; k < n; k++) begin
         a = addr + 32'(k);
         model_mem[a[11:0]] = wd[8*k +: 8];
      end
   endtask

   task automatic set_byte(input logic [31:0] addr, input logic [7:0] v);
      ram[addr[11:0]] = v;
      model_mem[addr[11:0]] = v;
   endtask

   // Issues one request, records the bus per cycle until the pulse, then idles one cycle.
   task automatic txn(input bit is_inst, input bit we, input logic [1:0] sz,
                      input logic [31:0] addr, input logic [31:0] wd);
      if (is_inst) begin
         inst_req = 1'b1; inst_addr = addr;
      end else begin
         data_req = 1'b1; data_we = we; data_size = sz; data_addr = addr; data_wdata = wd;
      end
      pulse_cyc = -1; pulse_inst = 1'b0; pulse_data = 1'b0;
      got_data = 32'h0; got_vaddr = 32'h0;
      for (int c = 1; c < 25; c++) begin
         @(negedge clk);
         tr_a[c] = mem_a; tr_wr[c] = mem_wr; tr_dout[c] = mem_dout;
         if (inst_valid || data_done) begin
            pulse_cyc = c; pulse_inst = inst_valid; pulse_data = data_done;
            got_data = inst_valid ? inst_data : data_rdata;
            got_vaddr = inst_valid_addr;
            break;
         end
      end
      inst_req = 1'b0; data_req = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      inst_req = 0; inst_addr = 0; data_req = 0; data_we = 0; data_size = 0;
      data_addr = 0; data_wdata = 0;
      repeat (3) @(negedge clk);
      total++; if ({inst_valid, data_done, mem_wr} !== 3'b000) begin bad++;
         $display("FAIL reset_pulses got=%b exp=000", {inst_valid, data_done, mem_wr}); end
      total++; if (inst_valid_addr !== 32'h0) begin bad++;
         $display("FAIL reset_vaddr got=%h exp=0", inst_valid_addr); end
      total++; if (inst_data !== 32'h0) begin bad++;
         $display("FAIL reset_inst_data got=%h exp=0", inst_data); end
      total++; if (data_rdata !== 32'h0) begin bad++;
         $display("FAIL reset_rdata got=%h exp=0", data_rdata); end
      total++; if (mem_a !== 32'h0 || mem_dout !== 8'h0) begin bad++;
         $display("FAIL reset_bus got a=%h dout=%h exp 0/0", mem_a, mem_dout); end
      rst = 1'b1;
      @(negedge clk);
      total++; if (mem_a !== 32'h0 || mem_wr !== 1'b0) begin bad++;
         $display("FAIL idle_bus got a=%h wr=%b exp 0/0", mem_a, mem_wr); end
   endtask

   task automatic test_fetch;
      set_byte(32'h100, 8'h13); set_byte(32'h101, 8'h05);
      set_byte(32'h102, 8'h00); set_byte(32'h103, 8'h00);
      txn(1'b1, 1'b0, 2'd2, 32'h100, 32'h0);
      total++; if (pulse_cyc !== 5 || !pulse_inst || pulse_data) begin bad++;
         $display("FAIL fetch_pulse got cyc=%0d i=%b d=%b exp cyc=5 i=1 d=0",
                  pulse_cyc, pulse_inst, pulse_data); end
      total++; if (got_data !== 32'h00000513) begin bad++;
         $display("FAIL fetch_data got=%h exp=00000513", got_data); end
      total++; if (got_vaddr !== 32'h100) begin bad++;
         $display("FAIL fetch_vaddr got=%h exp=00000100", got_vaddr); end
      for (int k = 0; k < 4; k++) begin
         total++; if (tr_a[k+1] !== 32'h100 + 32'(k) || tr_wr[k+1] !== 1'b0) begin bad++;
            $display("FAIL fetch_addr%0d got a=%h wr=%b exp a=%h wr=0",
                     k, tr_a[k+1], tr_wr[k+1], 32'h100 + 32'(k)); end
      end
      total++; if (inst_valid !== 1'b0) begin bad++;
         $display("FAIL fetch_single_pulse got inst_valid=%b exp=0", inst_valid); end
   endtask

   task automatic test_conflict;
      int dcyc, icyc, both;
      logic [31:0] drd, ird, iexp;
      set_byte(32'h200, 8'hEF); set_byte(32'h201, 8'hBE);
      set_byte(32'h202, 8'hAD); set_byte(32'h203, 8'hDE);
      iexp = model_read(32'h300, 4);
      dcyc = -1; icyc = -1; both = 0; drd = 0; ird = 0;
      inst_req = 1'b1; inst_addr = 32'h300;
      data_req = 1'b1; data_we = 1'b0; data_size = 2'd2; data_addr = 32'h200;
      for (int c = 1; c < 30; c++) begin
         @(negedge clk);
         if (inst_valid && data_done) both++;
         if (data_done) begin dcyc = c; drd = data_rdata; data_req = 1'b0; end
         if (inst_valid) begin icyc = c; ird = inst_data; inst_req = 1'b0; break; end
      end
      inst_req = 1'b0; data_req = 1'b0;
      @(negedge clk);
      total++; if (dcyc !== 5 || drd !== 32'hDEADBEEF) begin bad++;
         $display("FAIL conflict_data got cyc=%0d d=%h exp cyc=5 d=deadbeef", dcyc, drd); end
      total++; if (icyc !== 11 || ird !== iexp) begin bad++;
         $display("FAIL conflict_inst got cyc=%0d d=%h exp cyc=11 d=%h", icyc, ird, iexp); end
      total++; if (both !== 0) begin bad++;
         $display("FAIL conflict_overlap got=%0d exp=0", both); end
   endtask

   task automatic test_store_half;
      int wrs;
      txn(1'b0, 1'b1, 2'd1, 32'h3FF, 32'h1234ABCD);
      model_write(32'h3FF, 2, 32'h1234ABCD);
      wrs = 0;
      for (int c = 1; c <= 3; c++) if (tr_wr[c]) wrs++;
      total++; if (wrs !== 2 || pulse_cyc !== 3 || !pulse_data || got_data !== 32'h0) begin bad++;
         $display("FAIL store_half_shape got wrs=%0d cyc=%0d d=%b r=%h exp 2/3/1/0",
                  wrs, pulse_cyc, pulse_data, got_data); end
      total++; if (!tr_wr[1] || tr_a[1] !== 32'h3FF || tr_dout[1] !== 8'hCD) begin bad++;
         $display("FAIL store_half_b0 got wr=%b a=%h d=%h exp 1/3ff/cd", tr_wr[1], tr_a[1], tr_dout[1]); end
      total++; if (!tr_wr[2] || tr_a[2] !== 32'h400 || tr_dout[2] !== 8'hAB) begin bad++;
         $display("FAIL store_half_b1 got wr=%b a=%h d=%h exp 1/400/ab", tr_wr[2], tr_a[2], tr_dout[2]); end
      txn(1'b0, 1'b0, 2'd0, 32'h400, 32'h0);
      total++; if (pulse_cyc !== 2 || got_data !== 32'h000000AB) begin bad++;
         $display("FAIL load_byte got cyc=%0d d=%h exp cyc=2 d=000000ab", pulse_cyc, got_data); end
   endtask

   task automatic test_redirect;
      int p1, p2;
      logic [31:0] va1, va2, d1, a7;
      p1 = -1; p2 = -1; va1 = 0; va2 = 0; d1 = 0; a7 = 0;
      inst_req = 1'b1; inst_addr = 32'h100;
      for (int c = 1; c < 30; c++) begin
         @(negedge clk);
         if (c == 1) inst_addr = 32'h180;
         if (c == 7) a7 = mem_a;
         if (inst_valid && p1 < 0) begin p1 = c; va1 = inst_valid_addr; d1 = inst_data; end
         else if (inst_valid) begin p2 = c; va2 = inst_valid_addr; inst_req = 1'b0; break; end
      end
      inst_req = 1'b0;
      @(negedge clk);
      total++; if (p1 !== 5 || va1 !== 32'h100 || d1 !== model_read(32'h100, 4)) begin bad++;
         $display("FAIL redirect_old got cyc=%0d va=%h d=%h exp cyc=5 va=00000100", p1, va1, d1); end
      total++; if (p2 !== 11 || va2 !== 32'h180 || a7 !== 32'h180) begin bad++;
         $display("FAIL redirect_new got cyc=%0d va=%h a=%h exp cyc=11 va=180 a=180", p2, va2, a7); end
   endtask

   task automatic test_reset_mid;
      int pulses;
      pulses = 0;
      inst_req = 1'b1; inst_addr = 32'h500;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      total++; if ({inst_valid, data_done, mem_wr} !== 3'b000 || mem_a !== 32'h0 ||
                   mem_dout !== 8'h0 || inst_data !== 32'h0 || data_rdata !== 32'h0 ||
                   inst_valid_addr !== 32'h0) begin bad++;
         $display("FAIL reset_mid_outputs got a=%h wr=%b iv=%b dd=%b id=%h rd=%h exp all 0",
                  mem_a, mem_wr, inst_valid, data_done, inst_data, data_rdata); end
      repeat (2) begin @(negedge clk); if (inst_valid || data_done) pulses++; end
      rst = 1'b1;
      txn(1'b1, 1'b0, 2'd2, 32'h500, 32'h0);
      total++; if (pulses !== 0 || pulse_cyc !== 5 || got_data !== model_read(32'h500, 4) ||
                   tr_a[1] !== 32'h500 || tr_a[4] !== 32'h503) begin bad++;
         $display("FAIL reset_mid_refetch got p=%0d cyc=%0d d=%h exp p=0 cyc=5 d=%h",
                  pulses, pulse_cyc, got_data, model_read(32'h500, 4)); end
   endtask

   task automatic test_wrap;
      set_byte(32'hFFFFFFFE, 8'h11); set_byte(32'hFFFFFFFF, 8'h22);
      set_byte(32'h00000000, 8'h33); set_byte(32'h00000001, 8'h44);
      txn(1'b0, 1'b0, 2'd2, 32'hFFFFFFFE, 32'h0);
      total++; if (tr_a[1] !== 32'hFFFFFFFE || tr_a[2] !== 32'hFFFFFFFF ||
                   tr_a[3] !== 32'h0 || tr_a[4] !== 32'h1) begin bad++;
         $display("FAIL wrap_addr got %h %h %h %h exp fffffffe ffffffff 0 1",
                  tr_a[1], tr_a[2], tr_a[3], tr_a[4]); end
      total++; if (pulse_cyc !== 5 || got_data !== 32'h44332211) begin bad++;
         $display("FAIL wrap_data got cyc=%0d d=%h exp cyc=5 d=44332211", pulse_cyc, got_data); end
   endtask

   task automatic test_random;
      int kind, n, wrs;
      logic [1:0] sz;
      logic [31:0] addr, wd, exp_d, a;
      bit trace_ok, ram_ok;
      for (int it = 0; it < 40; it++) begin
         kind = int'($urandom_range(0, 2));
         sz = 2'($urandom_range(0, 3));
         addr = $urandom;
         wd = $urandom;
         if (kind == 0) begin addr = addr & 32'hFFFFFFFC; n = 4; end
         else n = nb(sz);
         exp_d = (kind == 1) ? model_read(addr, n) : (kind == 0) ? model_read(addr, 4) : 32'h0;
         txn(kind == 0, kind == 2, sz, addr, wd);
         if (kind == 2) model_write(addr, n, wd);
         trace_ok = 1'b1; wrs = 0;
         for (int k = 0; k < n; k++) begin
            if (tr_a[k+1] !== addr + 32'(k)) trace_ok = 1'b0;
            if (kind == 2 && tr_dout[k+1] !== wd[8*k +: 8]) trace_ok = 1'b0;
         end
         for (int c = 1; c <= n + 1 && c < 25; c++) if (tr_wr[c]) wrs++;
         ram_ok = 1'b1;
         for (int k = 0; k < n; k++) begin
            a = addr + 32'(k);
            if (ram[a[11:0]] !== model_mem[a[11:0]]) ram_ok = 1'b0;
         end
         total++;
         if (pulse_cyc !== n + 1 || pulse_inst !== (kind == 0) || pulse_data !== (kind != 0) ||
             got_data !== exp_d || (kind == 0 && got_vaddr !== addr) || !trace_ok ||
             wrs !== ((kind == 2) ? n : 0) || !ram_ok) begin
            bad++;
            $display("FAIL random%0d kind=%0d a=%h n=%0d got cyc=%0d d=%h wrs=%0d tr=%b ram=%b exp cyc=%0d d=%h",
                     it, kind, addr, n, pulse_cyc, got_data, wrs, trace_ok, ram_ok, n + 1, exp_d);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 4096; i++) begin
         ram[i] = 8'($urandom);
         model_mem[i] = ram[i];
      end
      test_reset;
      test_fetch;
      test_conflict;
      test_store_half;
      test_redirect;
      test_reset_mid;
      test_wrap;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
